// File: rtl/smc_apb_lite_master.sv
// smc_apb_lite_master: single-outstanding APB master with ACCESS wait timeout
module smc_apb_lite_master #(
   parameter logic [7:0] TIMEOUT = 8'd16
) (
   input  logic        pclk,
   input  logic        preset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [4:0]  req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        psel,
   output logic        penable,
   output logic        pwrite,
   output logic [4:0]  paddr,
   output logic [31:0] pwdata,
   input  logic [31:0] prdata,
   input  logic        pready
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
   state_t state;
   logic [7:0] cnt;
   logic timeout_hit;
   assign timeout_hit = (TIMEOUT != 8'd0) && (cnt == TIMEOUT);
   always_ff @(posedge pclk) begin
      if (preset) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         req_ready <= 1'b0;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= 5'd0;
         pwdata    <= 32'd0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= 32'd0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  state     <= SETUP;
                  req_ready <= 1'b0;
                  psel      <= 1'b1;
                  pwrite    <= req_write;
                  paddr     <= req_addr;
                  pwdata    <= req_wdata;
               end else begin
                  req_ready <= 1'b1;
               end
            end
            SETUP: begin
               state   <= ACCESS;
               penable <= 1'b1;
               cnt     <= 8'd0;
            end
            ACCESS: begin
               // pready wins over a timeout reached in the same cycle
               if (pready || timeout_hit) begin
                  state     <= IDLE;
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  req_ready <= 1'b1;
                  rsp_valid <= 1'b1;
                  rsp_err   <= !pready;
                  rsp_rdata <= (pready && !pwrite) ? prdata : 32'd0;
               end else begin
                  cnt <= (cnt == 8'hFF) ? cnt : cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_smc_apb_lite_master.sv
// tb_smc_apb_lite_master: directed checks of handshake, waits, timeout and reset
module tb_smc_apb_lite_master;
   logic        pclk = 1'b0;
   logic        preset, req_valid, req_valid0, req_write, pready, pready0;
   logic [4:0]  req_addr;
   logic [31:0] req_wdata, prdata;
   logic        req_ready, rsp_valid, rsp_err, psel, penable, pwrite;
   logic [31:0] rsp_rdata, pwdata;
   logic [4:0]  paddr;
   logic        req_ready0, rsp_valid0, rsp_err0, psel0, penable0, pwrite0;
   logic [31:0] rsp_rdata0, pwdata0;
   logic [4:0]  paddr0;
   int n_chk = 0;
   int n_fail = 0;
   int pulses;
   logic [11:0] acc_mask;

   always #5 pclk = ~pclk;

   smc_apb_lite_master #(.TIMEOUT(8'd3)) dut (
      .pclk(pclk), .preset(preset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .prdata(prdata), .pready(pready)
   );

   smc_apb_lite_master #(.TIMEOUT(8'd0)) dut0 (
      .pclk(pclk), .preset(preset), .req_valid(req_valid0), .req_ready(req_ready0),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
      .psel(psel0), .penable(penable0), .pwrite(pwrite0), .paddr(paddr0),
      .pwdata(pwdata0), .prdata(prdata), .pready(pready0)
   );

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic w, input logic [4:0] a, input logic [31:0] d);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      tick();
      req_valid = 1'b0;
   endtask

   initial begin
      preset = 1'b1; req_valid = 1'b0; req_valid0 = 1'b0; req_write = 1'b0;
      req_addr = 5'd0; req_wdata = 32'd0; prdata = 32'd0; pready = 1'b1; pready0 = 1'b0;
      tick(); tick();
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_psel", {31'd0, psel}, 32'd0);
      chk("rst_penable", {31'd0, penable}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_paddr", {27'd0, paddr}, 32'd0);
      chk("rst_pwdata", pwdata, 32'd0);
      preset = 1'b0;
      tick();
      chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

      // zero-wait read
      pready = 1'b1; prdata = 32'hA5A5_0001;
      req(1'b0, 5'h00, 32'd0);
      chk("rd_setup_psel", {31'd0, psel}, 32'd1);
      chk("rd_setup_penable", {31'd0, penable}, 32'd0);
      chk("rd_setup_ready", {31'd0, req_ready}, 32'd0);
      tick();
      chk("rd_access_psel", {31'd0, psel}, 32'd1);
      chk("rd_access_penable", {31'd0, penable}, 32'd1);
      tick();
      chk("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rd_rsp_rdata", rsp_rdata, 32'hA5A5_0001);
      chk("rd_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("rd_done_psel", {31'd0, psel}, 32'd0);
      chk("rd_done_penable", {31'd0, penable}, 32'd0);
      chk("rd_done_ready", {31'd0, req_ready}, 32'd1);
      tick();
      chk("rd_pulse_width", {31'd0, rsp_valid}, 32'd0);
      chk("rd_rdata_hold", rsp_rdata, 32'hA5A5_0001);

      // write with two wait states
      pready = 1'b0; prdata = 32'h1234_5678;
      req(1'b1, 5'h04, 32'hDEAD_BEEF);
      chk("wr_setup_paddr", {27'd0, paddr}, 32'h4);
      chk("wr_setup_pwdata", pwdata, 32'hDEAD_BEEF);
      chk("wr_setup_pwrite", {31'd0, pwrite}, 32'd1);
      tick();
      chk("wr_a1_pwdata", pwdata, 32'hDEAD_BEEF);
      tick();
      chk("wr_a2_penable", {31'd0, penable}, 32'd1);
      chk("wr_a2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      tick();
      chk("wr_a3_paddr", {27'd0, paddr}, 32'h4);
      chk("wr_a3_pwdata", pwdata, 32'hDEAD_BEEF);
      pready = 1'b1;
      tick();
      chk("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("wr_rsp_rdata", rsp_rdata, 32'd0);
      chk("wr_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("wr_idle_paddr_hold", {27'd0, paddr}, 32'h4);
      tick();
      chk("wr_single_pulse", {31'd0, rsp_valid}, 32'd0);

      // timeout with TIMEOUT=3: abort after the 4th ACCESS cycle
      pready = 1'b0; prdata = 32'hFFFF_0000;
      req(1'b0, 5'h08, 32'd0);
      tick(); tick(); tick(); tick();
      chk("to_a4_penable", {31'd0, penable}, 32'd1);
      chk("to_a4_no_rsp", {31'd0, rsp_valid}, 32'd0);
      tick();
      chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("to_rsp_err", {31'd0, rsp_err}, 32'd1);
      chk("to_rsp_rdata", rsp_rdata, 32'd0);
      chk("to_psel", {31'd0, psel}, 32'd0);
      chk("to_penable", {31'd0, penable}, 32'd0);
      chk("to_ready", {31'd0, req_ready}, 32'd1);
      pready = 1'b1; prdata = 32'hCAFE_0001;
      req(1'b0, 5'h09, 32'd0);
      chk("to_next_psel", {31'd0, psel}, 32'd1);
      chk("to_err_hold", {31'd0, rsp_err}, 32'd1);
      tick(); tick();
      chk("to_next_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("to_next_err", {31'd0, rsp_err}, 32'd0);
      chk("to_next_rdata", rsp_rdata, 32'hCAFE_0001);
      tick();

      // pready arrives on the cycle the timeout is reached
      pready = 1'b0; prdata = 32'h5555_AAAA;
      req(1'b0, 5'h0A, 32'd0);
      tick(); tick(); tick(); tick();
      pready = 1'b1;
      tick();
      chk("bnd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bnd_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("bnd_rsp_rdata", rsp_rdata, 32'h5555_AAAA);
      tick();

      // back-to-back zero-wait writes
      pready = 1'b1; pulses = 0; acc_mask = 12'd0;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 5'h11; req_wdata = 32'h0BAD_F00D;
      for (int i = 0; i < 12; i++) begin
         if (req_valid && req_ready) acc_mask[i] = 1'b1;
         if (rsp_valid) pulses++;
         tick();
         if (i == 6) req_valid = 1'b0;
      end
      chk("b2b_accept_cycles", {20'd0, acc_mask}, 32'h049);
      chk("b2b_pulses", pulses, 32'd3);

      // reset in the middle of ACCESS
      pready = 1'b0; prdata = 32'h1111_2222;
      req(1'b1, 5'h03, 32'h3333_4444);
      tick();
      chk("rst_mid_penable_pre", {31'd0, penable}, 32'd1);
      preset = 1'b1;
      tick();
      chk("rstm_psel", {31'd0, psel}, 32'd0);
      chk("rstm_penable", {31'd0, penable}, 32'd0);
      chk("rstm_pwrite", {31'd0, pwrite}, 32'd0);
      chk("rstm_paddr", {27'd0, paddr}, 32'd0);
      chk("rstm_pwdata", pwdata, 32'd0);
      chk("rstm_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rstm_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("rstm_rsp_rdata", rsp_rdata, 32'd0);
      chk("rstm_req_ready", {31'd0, req_ready}, 32'd0);
      preset = 1'b0; pready = 1'b1;
      tick();
      chk("rstm_ready_after", {31'd0, req_ready}, 32'd1);
      chk("rstm_no_rsp", {31'd0, rsp_valid}, 32'd0);
      tick();
      chk("rstm_no_rsp2", {31'd0, rsp_valid}, 32'd0);

      // TIMEOUT=0 waits indefinitely, past counter saturation
      pready0 = 1'b0; pulses = 0;
      req_valid0 = 1'b1; req_write = 1'b0; req_addr = 5'h01;
      tick();
      req_valid0 = 1'b0;
      tick();
      for (int i = 0; i < 300; i++) begin
         if (rsp_valid0) pulses++;
         tick();
      end
      chk("t0_no_rsp", pulses, 32'd0);
      chk("t0_penable", {31'd0, penable0}, 32'd1);
      pready0 = 1'b1; prdata = 32'h7777_0077;
      tick();
      chk("t0_rsp_valid", {31'd0, rsp_valid0}, 32'd1);
      chk("t0_rsp_err", {31'd0, rsp_err0}, 32'd0);
      chk("t0_rsp_rdata", rsp_rdata0, 32'h7777_0077);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
